// File: rtl/alu_muldiv.sv
// EX-stage ALU for the MIPS core. Single-cycle logic/arithmetic ops plus an
// iterative shift-add multiplier / restoring divider that writes HI/LO.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ANDN  = 4'b0100;
  localparam logic [3:0] OP_ORN   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CW-1:0]      count_r;
  logic [3:0]         op_r;
  logic               sign_a_r, sign_b_r, div0_r;
  logic [WIDTH-1:0]   a_r, mag_b_r;
  logic [2*WIDTH-1:0] work_r;

  logic [WIDTH-1:0]   result_r, hi_r, lo_r;
  logic               zero_r, ovf_r, busy_r, done_r;

  logic [WIDTH-1:0]   sum_s, diff_s, alu_res_s, mag_a_s, mag_b_s;
  logic               alu_ovf_s, is_muldiv_s, is_signed_s, is_div0_s, op_is_mul_s;
  logic [WIDTH:0]     mul_sum_s, div_trial_s;
  logic [2*WIDTH-1:0] mul_step_s, div_step_s, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fix_hi_s, fix_lo_s;

  assign sum_s       = a + b;
  assign diff_s      = a - b;
  assign is_muldiv_s = (sel == OP_MULT) || (sel == OP_MULTU) || (sel == OP_DIV) || (sel == OP_DIVU);
  assign is_signed_s = (sel == OP_MULT) || (sel == OP_DIV);
  assign is_div0_s   = ((sel == OP_DIV) || (sel == OP_DIVU)) && (b == {WIDTH{1'b0}});
  assign op_is_mul_s = (op_r == OP_MULT) || (op_r == OP_MULTU);

  // Iteration runs on magnitudes: low half starts as |a|, high half as 0.
  assign mul_sum_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]} + (work_r[0] ? {1'b0, mag_b_r} : {(WIDTH+1){1'b0}});
  assign mul_step_s  = {mul_sum_s, work_r[WIDTH-1:1]};
  assign div_trial_s = work_r[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b_r};
  assign div_step_s  = div_trial_s[WIDTH] ? {work_r[2*WIDTH-2:0], 1'b0}
                                          : {div_trial_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};

  // Single-cycle result and signed overflow.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (sel)
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  alu_res_s = a ^ b;
      OP_ANDN: alu_res_s = a & ~b;
      OP_ORN:  alu_res_s = a | ~b;
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Operand magnitudes captured at launch.
  always_comb begin
    mag_a_s = a;
    mag_b_s = b;
    if (is_signed_s && a[WIDTH-1]) begin
      mag_a_s = -a;
    end else begin
      mag_a_s = a;
    end
    if (is_signed_s && b[WIDTH-1]) begin
      mag_b_s = -b;
    end else begin
      mag_b_s = b;
    end
  end

  // Sign correction and HI/LO selection applied in FIX.
  always_comb begin
    prod_s   = work_r;
    quo_s    = work_r[WIDTH-1:0];
    rem_s    = work_r[2*WIDTH-1:WIDTH];
    fix_hi_s = {WIDTH{1'b0}};
    fix_lo_s = {WIDTH{1'b0}};
    if (sign_a_r ^ sign_b_r) begin
      prod_s = -work_r;
      quo_s  = -work_r[WIDTH-1:0];
    end else begin
      prod_s = work_r;
      quo_s  = work_r[WIDTH-1:0];
    end
    // Remainder takes the dividend's sign.
    if (sign_a_r) begin
      rem_s = -work_r[2*WIDTH-1:WIDTH];
    end else begin
      rem_s = work_r[2*WIDTH-1:WIDTH];
    end
    if (op_is_mul_s) begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end else if (div0_r) begin
      fix_hi_s = a_r;
      fix_lo_s = {WIDTH{1'b1}};
    end else begin
      fix_hi_s = rem_s;
      fix_lo_s = quo_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start && is_muldiv_s) begin
          if (is_div0_s) begin
            state_nxt_s = S_FIX;
          end else begin
            state_nxt_s = S_ITER;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ITER: begin
        if (count_r == CNT_LAST) begin
          state_nxt_s = S_FIX;
        end else begin
          state_nxt_s = S_ITER;
        end
      end
      S_FIX:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath, iteration registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= {CW{1'b0}};
      op_r     <= 4'b0000;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      div0_r   <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      mag_b_r  <= {WIDTH{1'b0}};
      work_r   <= {(2*WIDTH){1'b0}};
      result_r <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_nxt_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (start && is_muldiv_s) begin
            op_r     <= sel;
            a_r      <= a;
            sign_a_r <= is_signed_s & a[WIDTH-1];
            sign_b_r <= is_signed_s & b[WIDTH-1];
            div0_r   <= is_div0_s;
            mag_b_r  <= mag_b_s;
            work_r   <= {{WIDTH{1'b0}}, mag_a_s};
            count_r  <= {CW{1'b0}};
          end else if (start) begin
            result_r <= alu_res_s;
            zero_r   <= (alu_res_s == {WIDTH{1'b0}});
            ovf_r    <= alu_ovf_s;
            done_r   <= 1'b1;
          end
        end
        S_ITER: begin
          work_r  <= op_is_mul_s ? mul_step_s : div_step_s;
          count_r <= count_r + CNT_ONE;
        end
        S_FIX: begin
          hi_r     <= fix_hi_s;
          lo_r     <= fix_lo_s;
          result_r <= fix_lo_s;
          zero_r   <= (fix_lo_s == {WIDTH{1'b0}});
          ovf_r    <= 1'b0;
          done_r   <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign result   = result_r;
  assign zero     = zero_r;
  assign overflow = ovf_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle datapath ALU for the MIPS core.
- Adds registered logic/arithmetic ops with a start/done handshake, signed overflow detection, and unsigned compare.
- Adds an iterative multiply/divide unit with HI/LO registers.
- Sits in the EX stage; the control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt/immediate).
- sel  input  4  operation select.
- start  input  1  launch operation; sampled only when busy=0.
- result  output  WIDTH  registered result; for MUL/DIV ops equals lo.
- zero  output  1  registered, result==0.
- overflow  output  1  registered signed overflow (ADD/SUB only, else 0).
- busy  output  1  multi-cycle op in progress.
- done  output  1  one-cycle pulse: result/flags/hi/lo valid.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: single clock domain (clk). rst_n is asynchronous and active-low.
- Reset values:
  - result, hi, lo = 0.
  - zero=0, overflow=0, busy=0, done=0.
  - FSM returns to IDLE.
  - Asserting reset mid-operation aborts it: no done pulse, hi/lo cleared.
- sel encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR.
  - 0100 A&~B; 0101 A|~B; 0110 SUB.
  - 0111 SLT (signed, result 1/0); 1000 SLTU (unsigned, result 1/0).
  - 1001 MULT (signed); 1010 MULTU.
  - 1011 DIV (signed); 1100 DIVU.
  - 1101-1111 invalid.
- Single-cycle ops (0000-1000, invalid):
  - On an edge with start=1 and busy=0, result/zero/overflow are registered and done=1 for the following cycle.
  - Latency 1. busy stays 0. hi/lo are unchanged.
  - Invalid sel: result=0, zero=1, overflow=0, done still pulses.
- ADD/SUB:
  - Arithmetic is modulo 2^WIDTH.
  - overflow=1 when the operands' signs make a same-sign add (or opposite-sign sub) produce a result of the other sign.
- FSM states:
  - IDLE: on start with sel=MUL/DIV, capture a, b, sel and operand signs; busy=1; go to ITER with count=0.
  - ITER: one shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes; count increments. After WIDTH steps go to FIX.
  - FIX: apply sign correction and write hi/lo. Set result=lo, zero=(lo==0), overflow=0. Pulse done=1, clear busy, return to IDLE.
- MUL/DIV latency: done is high exactly WIDTH+2 cycles after the start edge. busy is high for WIDTH+1 cycles and falls on the same edge that done rises.
- Multiply: {hi,lo} = full 2*WIDTH-bit product (signed or unsigned per sel).
- Divide:
  - lo = quotient, truncated toward zero.
  - hi = remainder; its sign follows the dividend (signed DIV).
  - DIV of most-negative by -1: lo = most-negative, hi = 0. No trap.
- Divide by zero (b==0):
  - Skips ITER; IDLE -> FIX directly, so done follows in 2 cycles.
  - lo = all ones, hi = a.
- Handshake:
  - start while busy=1 is ignored; there is no queueing.
  - start on the same edge that done rises (busy=0 in that cycle) is accepted as a new op.
  - Operand changes during busy have no effect, because operands were captured at start.
- Output holding: result/zero/overflow hold between operations. hi/lo hold until the next MUL/DIV FIX.

Test Plan:
- Reset: assert rst_n=0 mid-MULT (count=10) -> next cycle all outputs 0, no done pulse. After release, ADD 5+7 -> result=12, done 1 cycle later.
- ADD 0x7FFFFFFF+1 -> result=0x80000000, overflow=1. SUB 5-5 -> result=0, zero=1, overflow=0. SLT 0xFFFFFFFF,1 -> 1. SLTU 0xFFFFFFFF,1 -> 0.
- MULT 0xFFFFFFFE (-2) x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA. done exactly 34 cycles after start, busy high 33 cycles.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 9/0 -> lo=0xFFFFFFFF, hi=9, done 2 cycles after start. A following ADD issued on the done cycle completes 1 cycle later.
- start pulses with new operands during a busy MULT -> ignored; final hi/lo reflect the original operands. Invalid sel 1111 -> result=0, zero=1, done pulses.
